// File: rtl/opl3_reg_wr_arbiter_if.sv
// OPL3 register-write record type and the bundle of request/result signals
// shared between the write sources and the arbiter.
package opl3_reg_wr_pkg;
    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;
endpackage

interface opl3_reg_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    import opl3_reg_wr_pkg::*;

    opl3_reg_wr_t [NUM_REQ-1:0] req_wr;
    opl3_reg_wr_t               opl3_reg_wr;
    logic [NUM_REQ-1:0]         req_pending;
    logic [NUM_REQ-1:0]         req_overflow;
    logic                       busy;

    modport master (
        output req_wr,
        input  opl3_reg_wr, req_pending, req_overflow, busy
    );

    modport slave (
        input  req_wr,
        output opl3_reg_wr, req_pending, req_overflow, busy
    );
endinterface

// File: rtl/opl3_reg_wr_arbiter.sv
// Per-requester FIFOs drained round-robin onto the single OPL3 register-write
// port, with a minimum spacing of MIN_GAP cycles between issued writes.
module opl3_reg_wr_arbiter
    import opl3_reg_wr_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MIN_GAP    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    opl3_reg_wr_arbiter_if.slave  bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int unsigned EW = 17;

    typedef enum logic {StIdle, StGap} state_e;

    logic [EW-1:0]      r_mem  [NUM_REQ][FIFO_DEPTH];
    logic [PW-1:0]      r_wptr [NUM_REQ];
    logic [PW-1:0]      r_rptr [NUM_REQ];
    logic [CW-1:0]      r_cnt  [NUM_REQ];
    logic [NUM_REQ-1:0] r_ovf;
    state_e             r_state, w_state_nxt;
    logic [GW-1:0]      r_gap, w_gap_nxt;
    logic [IW-1:0]      r_last, w_last_nxt;
    opl3_reg_wr_t       r_out, w_out_nxt;

    logic [NUM_REQ-1:0] w_nonempty, w_full, w_pop, w_push, w_drop;
    logic               w_grant_vld;
    logic [IW-1:0]      w_grant_idx;

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_nonempty[i] = (r_cnt[i] != '0);
            w_full[i]     = (r_cnt[i] == CW'(FIFO_DEPTH));
        end
    end

    // A full FIFO still accepts a push when the scheduler pops it this cycle.
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_push[i] = bus.req_wr[i].valid && (!w_full[i] || w_pop[i]);
            w_drop[i] = bus.req_wr[i].valid && w_full[i] && !w_pop[i];
        end
    end

    // Descending scan so the lowest offset from last_grant+1 is kept.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            if (w_nonempty[(int'(r_last) + k) % int'(NUM_REQ)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IW'((int'(r_last) + k) % int'(NUM_REQ));
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gap_nxt       = r_gap;
        w_last_nxt      = r_last;
        w_pop           = '0;
        w_out_nxt       = r_out;
        w_out_nxt.valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_grant_vld) begin
                    w_pop[w_grant_idx] = 1'b1;
                    w_out_nxt   = {1'b1, r_mem[w_grant_idx][r_rptr[w_grant_idx]]};
                    w_last_nxt  = w_grant_idx;
                    w_gap_nxt   = GW'(MIN_GAP - 1);
                    w_state_nxt = (MIN_GAP == 1) ? StIdle : StGap;
                end
            end
            StGap: begin
                w_gap_nxt = r_gap - GW'(1);
                if (r_gap == GW'(1)) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_gap   <= '0;
            r_last  <= IW'(NUM_REQ - 1);
            r_out   <= '0;
            r_ovf   <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_last  <= w_last_nxt;
            r_out   <= w_out_nxt;
            r_ovf   <= r_ovf | w_drop;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
                if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + CW'(1);
                else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - CW'(1);
            end
        end
    end

    // Storage needs no reset: the counters alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= {bus.req_wr[i].bank_num, bus.req_wr[i].address,
                                        bus.req_wr[i].data};
            end
        end
    end

    assign bus.opl3_reg_wr  = r_out;
    assign bus.req_pending  = w_nonempty;
    assign bus.req_overflow = r_ovf;
    assign bus.busy         = (|w_nonempty) || (r_state == StGap);
endmodule

// File: doc/opl3_reg_wr_arbiter.md
# opl3_reg_wr_arbiter

Shares the single OPL3 register-write port (`opl3_reg_wr_t`) between `NUM_REQ` independent write sources, e.g. `host_if` and an on-chip playback/boot-init engine. Each source gets a small FIFO that absorbs single-cycle `valid` pulses. A round-robin scheduler drains the FIFOs onto `opl3_reg_wr` and enforces a minimum spacing between issued writes. The block sits in the `clk` (OPL3) domain between the write sources and the register file.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `FIFO_DEPTH`, default 4: entries per requester FIFO; power of 2, ≥2.
- `MIN_GAP`, default 32: minimum number of `clk` cycles from one output `valid` to the next; ≥1.

Ports:
- `clk`, in, 1: OPL3 clock. Single clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_wr`, in, `opl3_reg_wr_t [NUM_REQ]`: per-requester write. `valid` is a one-cycle pulse; `bank_num`, `address` and `data` are sampled with it.
- `opl3_reg_wr`, out, `opl3_reg_wr_t`: arbitrated write. `valid` is a one-cycle pulse.
- `req_pending`, out, `NUM_REQ`: bit i is high while FIFO i is non-empty.
- `req_overflow`, out, `NUM_REQ`: bit i is a sticky flag set when a write to FIFO i is dropped.
- `busy`, out, 1: high when any FIFO is non-empty or the FSM is in GAP.

## Operation
**FIFOs**
- On `req_wr[i].valid`, push `{bank_num, address, data}` into FIFO i.
- If FIFO i is full (count sampled before any same-cycle pop) and no pop of FIFO i occurs in that cycle, drop the entry and set `req_overflow[i]`.
- A push and a pop in the same cycle on a full FIFO are both accepted.
- FIFO order is strictly preserved per requester.

**Scheduler FSM** (states IDLE, GAP)
- IDLE with at least one non-empty FIFO:
  - Grant the first non-empty requester searching from `last_grant+1`, modulo `NUM_REQ`.
  - Pop that FIFO, register its entry onto `opl3_reg_wr` with `valid=1`, and update `last_grant`.
  - Load `gap_cnt = MIN_GAP-1`.
  - Go to GAP, or stay in IDLE if `MIN_GAP==1`.
- GAP: decrement `gap_cnt` each cycle. Return to IDLE on the edge where `gap_cnt==1`.
- IDLE with all FIFOs empty: stay in IDLE.

**Output and flags**
- `opl3_reg_wr.valid` is high for exactly one cycle per grant.
- `bank_num`, `address` and `data` hold their last granted values while `valid` is low.
- `req_overflow` clears only on `reset`.

**Reset** (asynchronous; takes effect immediately, including mid-GAP or mid-push)
- All FIFOs are emptied.
- `opl3_reg_wr` = 0 (all fields).
- `req_pending` = 0, `req_overflow` = 0, `busy` = 0.
- FSM goes to IDLE, `gap_cnt` = 0, `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
- Entries pushed before the reset are never issued.

## Timing
- **Latency:** input `valid` in cycle n, with the FSM in IDLE and all FIFOs empty → `opl3_reg_wr.valid` in cycle n+2. This is one cycle for the FIFO write and one for the grant/output register.
- **Spacing:** with output `valid` in cycle c, the next output `valid` is no earlier than cycle c+`MIN_GAP`. It occurs exactly at c+`MIN_GAP` if any FIFO is non-empty by then.
- **`req_pending[i]`:** rises the cycle after the push and falls the cycle after the pop that empties FIFO i.
- **`req_overflow[i]`:** rises the cycle after the dropped push.
- **Same-cycle requests:** pulses on several requesters in the same cycle are all enqueued. Service order follows the round-robin rule; no request is starved beyond (`NUM_REQ`-1) × `MIN_GAP` cycles per ahead-queued grant.
- **Wrap-around:** FIFO pointers wrap modulo `FIFO_DEPTH`. `last_grant` wraps modulo `NUM_REQ`.

## Test plan
1. **Single write.** `MIN_GAP=32`; `req_wr[0]` = {bank 0, addr 0xA0, data 0x41} in cycle 10 → `opl3_reg_wr` = {valid 1, bank 0, addr 0xA0, data 0x41} in cycle 12 only. Fields hold afterwards; `busy` is low from cycle 43.
2. **Simultaneous requests.** Cycle n: req0 = {0, 0xA0, 0x41} and req1 = {1, 0xB0, 0x22} → req0 write in cycle n+2, req1 write in cycle n+34. `req_pending` = 2'b10 during cycles n+2..n+33.
3. **Round-robin fairness.** Three pulses each on req0 and req1, interleaved in cycles n..n+5 → output order 0,1,0,1,0,1 with a spacing of exactly 32 cycles.
4. **Overflow.** `FIFO_DEPTH=4`, `MIN_GAP=32`; six back-to-back pulses on req0 (data 0x01..0x06) → data 0x01..0x05 issued in order, 0x06 dropped. `req_overflow[0]=1` from cycle n+6; `req_overflow[1]` stays 0.
5. **Back-to-back.** `MIN_GAP=1`; four pulses on req1 in cycles n..n+3 → `valid` high in cycles n+2..n+5 with matching data.
6. **Reset mid-GAP.** Three entries queued on req0; assert `reset` asynchronously 5 cycles after the first output → all outputs zero immediately. After deassertion there is no further `valid`, `req_pending`=0 and `busy`=0.
